// File: rtl/serial_xfer.sv
// Multi-byte UART transaction engine: sends up to MAX_BYTES bytes to uart_tx,
// then collects up to MAX_BYTES reply bytes from uart_rx, with per-byte reply timeout.
module serial_xfer #(
  parameter int MAX_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FLUSH_RX       = 1,
  parameter int LEN_W          = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8*MAX_BYTES-1:0] xfer_tx_data,
  input  logic [LEN_W-1:0]       xfer_tx_len,
  input  logic [LEN_W-1:0]       xfer_rx_len,
  input  logic                   xfer_start,
  output logic                   xfer_busy,
  output logic                   xfer_done,
  output logic                   xfer_timeout,
  output logic [8*MAX_BYTES-1:0] xfer_rx_data,
  output logic [LEN_W-1:0]       xfer_rx_count,
  output logic [7:0]             tx_data,
  output logic                   tx_wr_strobe,
  input  logic                   tx_busy,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_rd_strobe,
  output logic [2:0]             state_dbg
);

  // Handshakes: tx_wr_strobe is a one-cycle write issued only when tx_busy was low;
  // rx_valid is level (byte waiting), rx_rd_strobe is a one-cycle acknowledge that
  // the uart uses to drop rx_valid. Neither strobe is ever high two cycles in a row.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SEND      = 3'd1;
  localparam logic [2:0] ST_SEND_WAIT = 3'd2;
  localparam logic [2:0] ST_RECV      = 3'd3;
  localparam logic [2:0] ST_RECV_ACK  = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);
  localparam logic [31:0]      TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]             state;
  logic [8*MAX_BYTES-1:0] tx_buf;
  logic [LEN_W-1:0]       tx_len;
  logic [LEN_W-1:0]       rx_len;
  logic [LEN_W-1:0]       idx;
  logic [31:0]            to_cnt;
  logic [LEN_W-1:0]       tx_len_c;
  logic [LEN_W-1:0]       rx_len_c;
  logic [7:0]             cur_tx_byte;

  assign state_dbg = state;
  assign tx_len_c  = (xfer_tx_len > MAX_LEN) ? MAX_LEN : xfer_tx_len;
  assign rx_len_c  = (xfer_rx_len > MAX_LEN) ? MAX_LEN : xfer_rx_len;

  always_comb begin
    cur_tx_byte = 8'h00;
    for (int k = 0; k < MAX_BYTES; k++) begin
      if (idx == LEN_W'(k)) cur_tx_byte = tx_buf[8*k +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      tx_buf        <= '0;
      tx_len        <= '0;
      rx_len        <= '0;
      idx           <= '0;
      to_cnt        <= '0;
      xfer_busy     <= 1'b0;
      xfer_done     <= 1'b0;
      xfer_timeout  <= 1'b0;
      xfer_rx_data  <= '0;
      xfer_rx_count <= '0;
      tx_data       <= 8'h00;
      tx_wr_strobe  <= 1'b0;
      rx_rd_strobe  <= 1'b0;
    end else begin
      tx_wr_strobe <= 1'b0;
      rx_rd_strobe <= 1'b0;
      xfer_done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer_start) begin
            tx_buf        <= xfer_tx_data;
            tx_len        <= tx_len_c;
            rx_len        <= rx_len_c;
            xfer_rx_data  <= '0;
            xfer_rx_count <= '0;
            xfer_timeout  <= 1'b0;
            idx           <= '0;
            to_cnt        <= '0;
            xfer_busy     <= 1'b1;
            if (tx_len_c != '0)      state <= ST_SEND;
            else if (rx_len_c != '0) state <= ST_RECV;
            else                     state <= ST_DONE;
          end else if ((FLUSH_RX != 0) && rx_valid && !rx_rd_strobe) begin
            // The uart drops rx_valid one cycle after the ack, so skip that cycle.
            rx_rd_strobe <= 1'b1;
          end
        end
        ST_SEND: begin
          if (!tx_busy) begin
            tx_data      <= cur_tx_byte;
            tx_wr_strobe <= 1'b1;
            idx          <= idx + LEN_W'(1);
            state        <= ST_SEND_WAIT;
          end
        end
        ST_SEND_WAIT: begin
          if (idx < tx_len) begin
            state <= ST_SEND;
          end else if (rx_len != '0) begin
            idx    <= '0;
            to_cnt <= '0;
            state  <= ST_RECV;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_RECV: begin
          if (rx_valid) begin
            for (int k = 0; k < MAX_BYTES; k++) begin
              if (idx == LEN_W'(k)) xfer_rx_data[8*k +: 8] <= rx_data;
            end
            rx_rd_strobe  <= 1'b1;
            idx           <= idx + LEN_W'(1);
            xfer_rx_count <= xfer_rx_count + LEN_W'(1);
            state         <= ST_RECV_ACK;
          end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST)) begin
            xfer_timeout <= 1'b1;
            state        <= ST_DONE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        ST_RECV_ACK: begin
          to_cnt <= '0;
          if (idx < rx_len) state <= ST_RECV;
          else              state <= ST_DONE;
        end
        ST_DONE: begin
          xfer_done <= 1'b1;
          xfer_busy <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_xfer.sv
// Bench for serial_xfer: behavioural uart_tx/uart_rx models stepped once per cycle,
// expected transaction results computed from the byte-level rules.
module tb_serial_xfer;
  localparam int MAX_BYTES      = 4;
  localparam int LEN_W          = $clog2(MAX_BYTES + 1);
  localparam int TIMEOUT_CYCLES = 100;
  localparam int DW             = 8 * MAX_BYTES;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b1;
  logic [DW-1:0]    xfer_tx_data = '0;
  logic [LEN_W-1:0] xfer_tx_len = '0;
  logic [LEN_W-1:0] xfer_rx_len = '0;
  logic             xfer_start = 1'b0;
  logic             xfer_busy, xfer_done, xfer_timeout;
  logic [DW-1:0]    xfer_rx_data;
  logic [LEN_W-1:0] xfer_rx_count;
  logic [7:0]       tx_data;
  logic             tx_wr_strobe;
  logic             tx_busy = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_valid = 1'b0;
  logic             rx_rd_strobe;
  logic [2:0]       state_dbg;

  logic             nf_rx_valid = 1'b0;
  logic             nf_busy, nf_done, nf_timeout, nf_wr, nf_rd;
  logic [DW-1:0]    nf_rx_data;
  logic [LEN_W-1:0] nf_rx_count;
  logic [7:0]       nf_tx_data;
  logic [2:0]       nf_state_dbg;

  serial_xfer #(.MAX_BYTES(MAX_BYTES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FLUSH_RX(1)) dut (
    .clk(clk), .reset(reset), .xfer_tx_data(xfer_tx_data), .xfer_tx_len(xfer_tx_len),
    .xfer_rx_len(xfer_rx_len), .xfer_start(xfer_start), .xfer_busy(xfer_busy),
    .xfer_done(xfer_done), .xfer_timeout(xfer_timeout), .xfer_rx_data(xfer_rx_data),
    .xfer_rx_count(xfer_rx_count), .tx_data(tx_data), .tx_wr_strobe(tx_wr_strobe),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_rd_strobe(rx_rd_strobe), .state_dbg(state_dbg)
  );

  serial_xfer #(.MAX_BYTES(MAX_BYTES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .FLUSH_RX(0)) dut_nf (
    .clk(clk), .reset(reset), .xfer_tx_data('0), .xfer_tx_len('0),
    .xfer_rx_len('0), .xfer_start(1'b0), .xfer_busy(nf_busy),
    .xfer_done(nf_done), .xfer_timeout(nf_timeout), .xfer_rx_data(nf_rx_data),
    .xfer_rx_count(nf_rx_count), .tx_data(nf_tx_data), .tx_wr_strobe(nf_wr),
    .tx_busy(1'b0), .rx_data(8'h33), .rx_valid(nf_rx_valid),
    .rx_rd_strobe(nf_rd), .state_dbg(nf_state_dbg)
  );

  int n_checks = 0;
  int n_err    = 0;

  // uart models and observation state
  int         cyc = 0;
  int         tx_busy_len = 0;
  int         busy_left = 0;
  int         busy_fall_cyc = 0;
  logic [7:0] tx_log[$];
  int         strobe_cyc[$];
  int         tx_target = 0;
  logic [7:0] reply_q[$];
  int         rep_gap = 5;
  bit         rep_armed = 0;
  int         rep_at = 0;
  int         ack_cyc = 0;
  int         rd_total = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         start_cyc = 0;
  int         nf_strobes = 0;
  bit         prev_wr = 0;
  bit         prev_rd = 0;
  logic [DW-1:0]    last_rx = '0;
  logic [LEN_W-1:0] last_cnt = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    return (v > MAX_BYTES) ? MAX_BYTES : v;
  endfunction

  task automatic reset_models();
    tx_busy = 1'b0; busy_left = 0; rx_valid = 1'b0;
    reply_q.delete(); rep_armed = 0; prev_wr = 0; prev_rd = 0;
  endtask

  // One clock: observe what the DUT produced at the last posedge, then update the uarts.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (tx_wr_strobe) begin
      check("wr_while_tx_busy", tx_busy, 0);
      check("wr_back_to_back", prev_wr, 0);
      tx_log.push_back(tx_data);
      strobe_cyc.push_back(cyc);
      if (tx_busy_len > 0) begin tx_busy = 1'b1; busy_left = tx_busy_len; end
      if (tx_log.size() == tx_target && reply_q.size() > 0) begin
        rep_armed = 1; rep_at = cyc + rep_gap;
      end
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin tx_busy = 1'b0; busy_fall_cyc = cyc; end
    end
    if (rx_rd_strobe) begin
      check("rd_without_valid", rx_valid, 1);
      check("rd_back_to_back", prev_rd, 0);
      rx_valid = 1'b0;
      rd_total++;
      ack_cyc = cyc;
      if (reply_q.size() > 0) begin rep_armed = 1; rep_at = cyc + rep_gap; end
    end
    if (rep_armed && !rx_valid && cyc >= rep_at) begin
      rx_valid = 1'b1;
      rx_data  = reply_q.pop_front();
      rep_armed = 0;
    end
    if (xfer_done) begin
      done_cnt++;
      done_cyc = cyc;
      check("busy_low_with_done", xfer_busy, 0);
    end
    if (nf_rd) nf_strobes++;
    prev_wr = tx_wr_strobe;
    prev_rd = rx_rd_strobe;
  endtask

  task automatic run_xfer(input string tag, input logic [DW-1:0] data, input int txl,
                          input int rxl, input logic [DW-1:0] reps, input int n_rep,
                          input int gap, input int busy_len, input int mid_start);
    int txc, rxc;
    logic [DW-1:0] exp_rx;
    txc = clampi(txl);
    rxc = clampi(rxl);
    exp_rx = '0;
    tx_log.delete(); strobe_cyc.delete(); reply_q.delete();
    done_cnt = 0; tx_target = txc; tx_busy_len = busy_len; rep_gap = gap;
    for (int i = 0; i < n_rep; i++) begin
      reply_q.push_back(reps[8*i +: 8]);
      exp_rx[8*i +: 8] = reps[8*i +: 8];
    end
    if (txc == 0 && n_rep > 0) begin rep_armed = 1; rep_at = cyc + gap; end
    xfer_tx_data = data;
    xfer_tx_len  = LEN_W'(txl);
    xfer_rx_len  = LEN_W'(rxl);
    xfer_start   = 1'b1;
    start_cyc    = cyc;
    tick();
    xfer_start = 1'b0;
    check({tag, "_busy_after_start"}, xfer_busy, 1);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      if (i == mid_start) xfer_start = 1'b1;
      tick();
      xfer_start = 1'b0;
    end
    check({tag, "_done_seen"}, done_cnt, 1);
    check({tag, "_timeout"}, xfer_timeout, (n_rep < rxc) ? 1 : 0);
    check({tag, "_rx_count"}, xfer_rx_count, n_rep);
    check({tag, "_rx_data"}, xfer_rx_data, exp_rx);
    check({tag, "_tx_bytes"}, tx_log.size(), txc);
    for (int i = 0; i < txc && i < tx_log.size(); i++)
      check({tag, "_tx_byte"}, tx_log[i], data[8*i +: 8]);
    tick();
    check({tag, "_idle_after_done"}, {xfer_busy, xfer_done}, 2'b00);
    last_rx  = exp_rx;
    last_cnt = LEN_W'(n_rep);
  endtask

  initial begin
    int d, rd0, txl, rxl, nrep;
    logic [DW-1:0] data, reps;

    reset = 1'b1;
    repeat (3) tick();
    check("rst_busy", xfer_busy, 0);
    check("rst_done", xfer_done, 0);
    check("rst_timeout", xfer_timeout, 0);
    check("rst_rx_data", xfer_rx_data, 0);
    check("rst_rx_count", xfer_rx_count, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_strobes", {tx_wr_strobe, rx_rd_strobe}, 2'b00);
    reset = 1'b0;
    tick();

    // Two bytes out, one-byte echo 20 cycles later.
    data = {16'($urandom), 16'h4241};
    run_xfer("echo", data, 2, 1, 32'h0000_0055, 1, 20, 3, -1);
    check("echo_rx_byte0", xfer_rx_data[7:0], 8'h55);
    repeat (8) tick();

    // uart_tx stays busy 50 cycles after the first write.
    run_xfer("slow_tx", 32'h0000_BEEF, 2, 0, '0, 0, 5, 50, -1);
    if (strobe_cyc.size() == 2)
      check("slow_tx_second_after_fall", strobe_cyc[1] > busy_fall_cyc, 1);
    repeat (60) tick();

    // Reply timeout after one byte of two.
    run_xfer("timeout", '0, 0, 2, 32'h0000_00A5, 1, 5, 0, -1);
    d = done_cyc - ack_cyc;
    check("timeout_latency_window", (d >= 100 && d <= 104) ? 1 : 0, 1);
    check("timeout_rx_word", xfer_rx_data, 32'h0000_00A5);

    // Zero-length transaction.
    rd0 = rd_total;
    run_xfer("zero", 32'h1234_5678, 0, 0, '0, 0, 5, 0, -1);
    check("zero_latency", done_cyc - start_cyc, 2);
    check("zero_no_rd", rd_total - rd0, 0);

    // Over-long length clamps; a start while busy is ignored.
    data = $urandom;
    run_xfer("clamp", data, 7, 0, '0, 0, 5, 2, 3);
    repeat (6) tick();
    check("clamp_no_second_xfer", {done_cnt, 31'(xfer_busy)}, {32'd1, 31'd0});

    // Randomized transactions against the byte-level model.
    for (int n = 0; n < 6; n++) begin
      txl  = $urandom_range(0, 6);
      rxl  = $urandom_range(0, 6);
      nrep = $urandom_range(0, clampi(rxl));
      data = $urandom;
      reps = $urandom;
      run_xfer("rand", data, txl, rxl, reps, nrep, $urandom_range(2, 30),
               $urandom_range(0, 6), -1);
      repeat (10) tick();
    end

    // Stray byte while idle: flushed once, results untouched; no flush when disabled.
    done_cnt = 0;
    rd0 = rd_total;
    nf_rx_valid = 1'b1;
    reply_q.push_back(8'h33);
    rep_armed = 1; rep_at = cyc + 2;
    repeat (10) tick();
    check("flush_one_strobe", rd_total - rd0, 1);
    check("flush_valid_cleared", rx_valid, 0);
    check("flush_rx_data_kept", xfer_rx_data, last_rx);
    check("flush_rx_count_kept", xfer_rx_count, last_cnt);
    check("flush_no_done", done_cnt, 0);
    check("noflush_no_strobe", nf_strobes, 0);
    check("noflush_idle", {nf_busy, nf_done, nf_wr}, 3'b000);
    nf_rx_valid = 1'b0;

    // Reset in the middle of SEND aborts without a done pulse.
    tx_log.delete(); tx_target = 4; tx_busy_len = 20; done_cnt = 0;
    xfer_tx_data = 32'hCAFE_F00D; xfer_tx_len = 3'd4; xfer_rx_len = 3'd2;
    xfer_start = 1'b1;
    tick();
    xfer_start = 1'b0;
    for (int i = 0; i < 20 && tx_log.size() == 0; i++) tick();
    check("rst_mid_first_byte", tx_log.size(), 1);
    reset = 1'b1;
    tick();
    check("rst_mid_outputs",
          {xfer_busy, xfer_done, xfer_timeout, tx_wr_strobe, rx_rd_strobe, tx_data},
          13'd0);
    check("rst_mid_rx", {xfer_rx_data, 29'(xfer_rx_count)}, 61'd0);
    reset_models();
    reset = 1'b0;
    repeat (40) tick();
    check("rst_mid_no_done", done_cnt, 0);
    check("rst_mid_no_more_tx", tx_log.size(), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_xfer.md
Name: serial_xfer

Overview:
Parametrised multi-byte UART transaction engine that replaces the single-character send/receive helper.
- On one start pulse it sends 0..MAX_BYTES bytes from a packed bus, then collects 0..MAX_BYTES reply bytes into a packed bus.
- A reply timeout and an optional idle-time RX flush are included.
- Sits between the register/host control logic and the uart_tx/uart_rx cores.

Parameters:
MAX_BYTES, 4, maximum bytes per direction per transaction (>=1)
TIMEOUT_CYCLES, 1000000, max cycles to wait for each reply byte; 0 disables the timeout
FLUSH_RX, 1, 1 = discard stray RX bytes while IDLE; 0 = leave them in the uart
LEN_W, $clog2(MAX_BYTES+1), width of the length/count fields (derived; do not override)

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
xfer_tx_data  in  8*MAX_BYTES  bytes to send; byte k at [8k+7:8k], byte 0 sent first
xfer_tx_len  in  LEN_W  number of bytes to send
xfer_rx_len  in  LEN_W  number of reply bytes expected
xfer_start  in  1  start request, sampled in IDLE only
xfer_busy  out  1  high from the cycle after an accepted start until done
xfer_done  out  1  one-cycle completion pulse
xfer_timeout  out  1  high with xfer_done when the reply timed out; held until next start
xfer_rx_data  out  8*MAX_BYTES  received bytes, byte k at [8k+7:8k]; unfilled bytes are 0
xfer_rx_count  out  LEN_W  bytes actually received
tx_data  out  8  byte to uart_tx
tx_wr_strobe  out  1  one-cycle write strobe to uart_tx
tx_busy  in  1  uart_tx busy
rx_data  in  8  byte from uart_rx
rx_valid  in  1  uart_rx holds an unread byte
rx_rd_strobe  out  1  one-cycle read-acknowledge to uart_rx

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Reset asserted mid-transaction aborts it; no done pulse is produced.
- States: IDLE, SEND, SEND_WAIT, RECV, RECV_ACK, DONE.
- IDLE, start accepted (xfer_start=1):
  - Latch tx data and both lengths; each length is clamped to MAX_BYTES.
  - Clear xfer_rx_data, xfer_rx_count and xfer_timeout; reset the byte index.
  - Next state: SEND if tx_len>0, else RECV if rx_len>0, else DONE.
- IDLE, no start, FLUSH_RX=1, rx_valid=1: pulse rx_rd_strobe, data discarded. Start takes priority over flush in the same cycle.
- SEND: when tx_busy=0, drive tx_data=byte[idx], pulse tx_wr_strobe for 1 cycle, increment idx, go to SEND_WAIT.
- SEND_WAIT: exactly 1 cycle; tx_busy is ignored to cover uart latency.
  - Next state: SEND if idx<tx_len, else RECV if rx_len>0, else DONE.
  - Reset idx to 0 when leaving for RECV.
- RECV:
  - On entry the timeout counter is 0.
  - rx_valid=1: store rx_data at byte idx, pulse rx_rd_strobe, increment idx and xfer_rx_count, go to RECV_ACK.
  - Else the counter increments. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without rx_valid, set xfer_timeout=1 and go to DONE.
  - rx_valid wins if it coincides with the timeout.
- RECV_ACK: 1 cycle, rx_valid ignored, timeout counter cleared. Next state: RECV if idx<rx_len, else DONE.
- DONE: xfer_done=1 for one cycle, xfer_busy=0 in the same cycle, then IDLE. Results stay stable until the next accepted start.
- Latency:
  - Zero-length transaction: start at cycle N gives done at N+2.
  - Each TX byte costs at least 2 cycles; each RX byte costs at least 2 cycles.
- xfer_start while busy is ignored (no queuing).
- Strobes never assert two consecutive cycles.
- tx_data holds its last value after use.

Test Plan:
- tx_len=2, data 0x..4241, rx_len=1, uart model echoes 0x55 after 20 cycles -> tx strobes carry 0x41 then 0x42 in order; rx_data[7:0]=0x55; rx_count=1; done pulse with timeout=0.
- tx_busy held high 50 cycles after the first strobe -> second strobe no earlier than the cycle after tx_busy falls; no strobe while busy.
- TIMEOUT_CYCLES=100, rx_len=2, only one byte 0xA5 arrives -> done with timeout=1, rx_count=1, rx_data=0x00A5, about 100 cycles after that byte's ack.
- tx_len=0, rx_len=0 -> done exactly 2 cycles after start; no strobes.
- tx_len=7 with MAX_BYTES=4 -> exactly 4 bytes sent. Start pulsed mid-transfer -> ignored. Reset mid-SEND -> all outputs 0 next cycle, no done.
- FLUSH_RX=1, stray byte 0x33 while idle -> one rx_rd_strobe, outputs unchanged. FLUSH_RX=0 -> no strobe and rx_valid stays high.
